dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_prio.sv | 57 +++++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and the
// default anti-starvation threshold for the debug/loader requester.
package dmem_pkg;

   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_C_ACC = 3'd1,
      ST_C_RSP = 3'd2,
      ST_D_ACC = 3'd3,
      ST_D_RSP = 3'd4
   } state_t;

endpackage

// File: rtl/dmem_prio.sv
// Core-first priority with anti-starvation: the debug requester wins once it
// has lost STARVE_MAX consecutive arbitration decisions.
module dmem_prio
   import dmem_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_decide,
   input  logic i_c_req,
   input  logic i_d_req,
   output logic o_grant_c,
   output logic o_grant_d
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic [CW-1:0] r_starve_cnt;
   logic          w_starved;

   // Grant selection from current requests and starvation state
   always_comb begin
      w_starved = (r_starve_cnt == CNT_MAX);
      o_grant_c = 1'b0;
      o_grant_d = 1'b0;
      if (i_c_req && !(i_d_req && w_starved)) begin
         o_grant_c = 1'b1;
      end else if (i_d_req) begin
         o_grant_d = 1'b1;
      end else begin
         o_grant_c = 1'b0;
         o_grant_d = 1'b0;
      end
   end

   // Count consecutive debug losses; only arbitration cycles move the count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_starve_cnt <= CNT_ZERO;
      end else if (i_decide) begin
         if (!i_d_req || o_grant_d) begin
            r_starve_cnt <= CNT_ZERO;
         end else if (o_grant_c && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + CNT_ONE;
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
      end else begin
         r_starve_cnt <= r_starve_cnt;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core and debug/loader share one
// single-port memory through a decide/access/respond sequence.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic [DW-1:0] c_rdata,
   output logic          c_ack,
   output logic          c_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          d_stall,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   state_t        r_state;
   logic          r_cmd_we;
   logic [AW-1:0] r_cmd_addr;
   logic [DW-1:0] r_cmd_wdata;
   logic          r_m_en;
   logic          r_m_we;
   logic          r_c_ack;
   logic          r_d_ack;
   logic [DW-1:0] r_c_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          w_decide;
   logic          w_grant_c;
   logic          w_grant_d;

   assign w_decide = (r_state == ST_IDLE);

   dmem_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_decide  (w_decide),
      .i_c_req   (c_req),
      .i_d_req   (d_req),
      .o_grant_c (w_grant_c),
      .o_grant_d (w_grant_d)
   );

   // Arbitration FSM with latched command and registered memory strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_m_en      <= 1'b0;
         r_m_we      <= 1'b0;
         r_c_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_c_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_c_ack <= 1'b0;
               r_d_ack <= 1'b0;
               if (w_grant_c) begin
                  r_cmd_we    <= c_we;
                  r_cmd_addr  <= c_addr;
                  r_cmd_wdata <= c_wdata;
                  r_m_en      <= 1'b1;
                  r_m_we      <= c_we;
                  r_state     <= ST_C_ACC;
               end else if (w_grant_d) begin
                  r_cmd_we    <= d_we;
                  r_cmd_addr  <= d_addr;
                  r_cmd_wdata <= d_wdata;
                  r_m_en      <= 1'b1;
                  r_m_we      <= d_we;
                  r_state     <= ST_D_ACC;
               end else begin
                  r_m_en  <= 1'b0;
                  r_m_we  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_C_ACC: begin
               r_m_en  <= 1'b0;
               r_m_we  <= 1'b0;
               r_c_ack <= 1'b1;
               r_state <= ST_C_RSP;
            end
            ST_C_RSP: begin
               r_c_ack <= 1'b0;
               if (!r_cmd_we) begin
                  r_c_rdata <= m_rdata;
               end
               r_state <= ST_IDLE;
            end
            ST_D_ACC: begin
               r_m_en  <= 1'b0;
               r_m_we  <= 1'b0;
               r_d_ack <= 1'b1;
               r_state <= ST_D_RSP;
            end
            ST_D_RSP: begin
               r_d_ack <= 1'b0;
               if (!r_cmd_we) begin
                  r_d_rdata <= m_rdata;
               end
               r_state <= ST_IDLE;
            end
            default: begin
               r_m_en  <= 1'b0;
               r_m_we  <= 1'b0;
               r_c_ack <= 1'b0;
               r_d_ack <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory read data only arrives in the respond cycle, so it is forwarded
   // there and the captured copy is presented afterwards.
   always_comb begin
      if ((r_state == ST_C_RSP) && !r_cmd_we) begin
         c_rdata = m_rdata;
      end else begin
         c_rdata = r_c_rdata;
      end
      if ((r_state == ST_D_RSP) && !r_cmd_we) begin
         d_rdata = m_rdata;
      end else begin
         d_rdata = r_d_rdata;
      end
   end

   assign c_ack   = r_c_ack;
   assign d_ack   = r_d_ack;
   assign c_stall = c_req & ~r_c_ack;
   assign d_stall = d_req & ~r_d_ack;
   assign m_en    = r_m_en;
   assign m_we    = r_m_we;
   assign m_addr  = r_cmd_addr;
   assign m_wdata = r_cmd_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and memory image.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_req, c_we, d_req, d_we;
   logic [AW-1:0] c_addr, d_addr;
   logic [DW-1:0] c_wdata, d_wdata;
   logic [DW-1:0] c_rdata, d_rdata;
   logic          c_ack, d_ack, c_stall, d_stall;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
   logic        prev_c_ack = 1'b0;
   logic        prev_d_ack = 1'b0;

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory with one-cycle read latency
   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (m_en) begin
         if (m_we) mem[m_addr[7:0]] <= m_wdata;
         else      m_rdata <= mem[m_addr[7:0]];
      end
   end

   // Advance one cycle and check the per-cycle invariants
   task automatic step();
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
         checks++;
         if (c_ack && d_ack) begin
            failures++;
            $display("FAIL ack_exclusive c_ack=%0b d_ack=%0b required not both 1", c_ack, d_ack);
         end
         checks++;
         if (m_we && !m_en) begin
            failures++;
            $display("FAIL we_implies_en m_we=%0b m_en=%0b", m_we, m_en);
         end
         checks++;
         if ((c_ack && prev_c_ack) || (d_ack && prev_d_ack)) begin
            failures++;
            $display("FAIL ack_width c_ack=%0b/%0b d_ack=%0b/%0b required single-cycle pulses",
                     prev_c_ack, c_ack, prev_d_ack, d_ack);
         end
      end
      prev_c_ack = c_ack;
      prev_d_ack = d_ack;
   endtask

   task automatic poke(input logic [7:0] a, input logic [31:0] v);
      ld_en = 1'b1; ld_addr = a; ld_data = v; ref_mem[a] = v;
      step();
      ld_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
      for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
      checks++;
      if ({c_ack, d_ack, m_en, m_we} !== 4'b0000) begin
         failures++;
         $display("FAIL rst_ctrl ack/en/we=%b required 0000", {c_ack, d_ack, m_en, m_we});
      end
      checks++;
      if (m_addr !== 32'd0 || m_wdata !== 32'd0) begin
         failures++;
         $display("FAIL rst_mbus m_addr=%h m_wdata=%h required 0", m_addr, m_wdata);
      end
      checks++;
      if (c_rdata !== 32'd0 || d_rdata !== 32'd0) begin
         failures++;
         $display("FAIL rst_rdata c_rdata=%h d_rdata=%h required 0", c_rdata, d_rdata);
      end
      rst = 1'b1;
      step();
      checks++;
      if (m_en !== 1'b0 || c_ack !== 1'b0) begin
         failures++;
         $display("FAIL rst_idle m_en=%0b c_ack=%0b required 0", m_en, c_ack);
      end
   endtask

   task automatic test_core_load();
      poke(8'h10, 32'hDEADBEEF);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      #1;
      checks++;
      if (c_stall !== 1'b1) begin
         failures++; $display("FAIL cl_stall_c1 c_stall=%0b required 1", c_stall);
      end
      step();
      checks++;
      if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h10 || c_stall !== 1'b1 || c_ack !== 1'b0) begin
         failures++;
         $display("FAIL cl_access en=%0b we=%0b addr=%h stall=%0b ack=%0b required 1 0 10 1 0",
                  m_en, m_we, m_addr, c_stall, c_ack);
      end
      step();
      checks++;
      if (c_ack !== 1'b1 || c_rdata !== 32'hDEADBEEF || c_stall !== 1'b0 || m_en !== 1'b0) begin
         failures++;
         $display("FAIL cl_resp ack=%0b rdata=%h stall=%0b en=%0b required 1 deadbeef 0 0",
                  c_ack, c_rdata, c_stall, m_en);
      end
      c_req = 1'b0;
      step();
      checks++;
      if (c_ack !== 1'b0 || m_en !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL cl_after ack=%0b en=%0b rdata=%h required 0 0 deadbeef", c_ack, m_en, c_rdata);
      end
   endtask

   task automatic test_debug_store();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
      step();
      checks++;
      if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h20 || m_wdata !== 32'h12345678) begin
         failures++;
         $display("FAIL ds_access en=%0b we=%0b addr=%h wdata=%h required 1 1 20 12345678",
                  m_en, m_we, m_addr, m_wdata);
      end
      step();
      checks++;
      if (d_ack !== 1'b1 || c_ack !== 1'b0 || m_en !== 1'b0 || d_rdata !== 32'd0) begin
         failures++;
         $display("FAIL ds_resp d_ack=%0b c_ack=%0b en=%0b d_rdata=%h required 1 0 0 0",
                  d_ack, c_ack, m_en, d_rdata);
      end
      ref_mem[8'h20] = 32'h12345678;
      d_req = 1'b0; d_we = 1'b0;
      step();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
      step();
      step();
      checks++;
      if (c_ack !== 1'b1 || c_rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL ds_readback ack=%0b rdata=%h required 1 12345678", c_ack, c_rdata);
      end
      c_req = 1'b0;
      step();
   endtask

   // Both held: the debug side wins every (SM+1)-th access, starting from zero losses
   task automatic test_contention(input bit withdraw);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = withdraw ? 32'h30 : 32'h20;
      for (int k = 0; k < 2 * (SM + 1); k++) begin
         bit exp_d;
         logic [31:0] exp_addr;
         exp_d = ((k % (SM + 1)) == SM);
         exp_addr = exp_d ? d_addr : c_addr;
         step();
         if (withdraw && exp_d) d_req = 1'b0;
         checks++;
         if (m_en !== 1'b1 || m_addr !== exp_addr) begin
            failures++;
            $display("FAIL cont_grant k=%0d en=%0b addr=%h required 1 %h", k, m_en, m_addr, exp_addr);
         end
         step();
         checks++;
         if (c_ack !== !exp_d || d_ack !== exp_d) begin
            failures++;
            $display("FAIL cont_ack k=%0d c_ack=%0b d_ack=%0b required %0b %0b",
                     k, c_ack, d_ack, !exp_d, exp_d);
         end
         if (exp_d) begin
            checks++;
            if (d_rdata !== ref_mem[d_addr[7:0]]) begin
               failures++;
               $display("FAIL cont_drdata k=%0d got=%h required %h", k, d_rdata, ref_mem[d_addr[7:0]]);
            end
            d_req = 1'b1;
         end
         step();
         checks++;
         if (m_en !== 1'b0 || c_ack !== 1'b0 || d_ack !== 1'b0) begin
            failures++;
            $display("FAIL cont_idle k=%0d en=%0b c_ack=%0b d_ack=%0b required 0 0 0", k, m_en, c_ack, d_ack);
         end
      end
      c_req = 1'b0; d_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      step();
      checks++;
      if (m_en !== 1'b1) begin
         failures++; $display("FAIL rm_access m_en=%0b required 1", m_en);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (m_en !== 1'b0 || c_ack !== 1'b0 || m_addr !== 32'd0) begin
         failures++;
         $display("FAIL rm_async en=%0b ack=%0b addr=%h required 0 0 0", m_en, c_ack, m_addr);
      end
      step();
      checks++;
      if (c_ack !== 1'b0 || m_en !== 1'b0) begin
         failures++; $display("FAIL rm_noack ack=%0b en=%0b required 0 0", c_ack, m_en);
      end
      #2 rst = 1'b1;
      step();
      checks++;
      if (m_en !== 1'b1 || c_ack !== 1'b0) begin
         failures++; $display("FAIL rm_reserve en=%0b ack=%0b required 1 0", m_en, c_ack);
      end
      step();
      checks++;
      if (c_ack !== 1'b1 || c_rdata !== ref_mem[8'h10]) begin
         failures++;
         $display("FAIL rm_resp ack=%0b rdata=%h required 1 %h", c_ack, c_rdata, ref_mem[8'h10]);
      end
      c_req = 1'b0;
      step();
   endtask

   task automatic test_random();
      bit pc = 1'b0, pd = 1'b0, c_known = 1'b0, d_known = 1'b0;
      int losses = 0;
      logic [31:0] last_c = '0, last_d = '0;
      for (int it = 0; it < 80; it++) begin
         bit win_d, e_we;
         logic [31:0] e_addr, e_wdata, e_rd;
         if (!pc && $urandom_range(0, 1) == 1) begin
            pc = 1'b1; c_we = 1'($urandom_range(0, 1));
            c_addr = 32'($urandom_range(0, 255)); c_wdata = $urandom;
         end
         if (!pd && $urandom_range(0, 2) != 0) begin
            pd = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
         end
         c_req = pc; d_req = pd;
         if (!pc && !pd) begin
            losses = 0;
            step();
            checks++;
            if (m_en !== 1'b0) begin
               failures++; $display("FAIL rnd_idle it=%0d m_en=%0b required 0", it, m_en);
            end
            continue;
         end
         win_d = pd && (!pc || losses == SM);
         if (!pd || win_d) losses = 0;
         else if (losses < SM) losses++;
         e_we    = win_d ? d_we : c_we;
         e_addr  = win_d ? d_addr : c_addr;
         e_wdata = win_d ? d_wdata : c_wdata;
         step();
         checks++;
         if (m_en !== 1'b1 || m_we !== e_we || m_addr !== e_addr || (e_we && m_wdata !== e_wdata)) begin
            failures++;
            $display("FAIL rnd_access it=%0d en=%0b we=%0b addr=%h wd=%h required 1 %0b %h %h",
                     it, m_en, m_we, m_addr, m_wdata, e_we, e_addr, e_wdata);
         end
         if (win_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
         else       begin c_addr = $urandom; c_wdata = $urandom; c_we = ~c_we; end
         step();
         checks++;
         if (c_ack !== !win_d || d_ack !== win_d) begin
            failures++;
            $display("FAIL rnd_ack it=%0d c_ack=%0b d_ack=%0b required %0b %0b",
                     it, c_ack, d_ack, !win_d, win_d);
         end
         if (e_we) begin
            ref_mem[e_addr[7:0]] = e_wdata;
         end else begin
            e_rd = ref_mem[e_addr[7:0]];
            if (win_d) begin last_d = e_rd; d_known = 1'b1; end
            else       begin last_c = e_rd; c_known = 1'b1; end
         end
         if (win_d ? d_known : c_known) begin
            checks++;
            if ((win_d ? d_rdata : c_rdata) !== (win_d ? last_d : last_c)) begin
               failures++;
               $display("FAIL rnd_rdata it=%0d got=%h required %h", it,
                        win_d ? d_rdata : c_rdata, win_d ? last_d : last_c);
            end
         end
         if (win_d) begin pd = 1'b0; d_req = 1'b0; end
         else       begin pc = 1'b0; c_req = 1'b0; end
         step();
      end
      c_req = 1'b0; d_req = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_core_load();
      test_debug_store();
      test_contention(1'b0);
      test_contention(1'b1);
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
